hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the DE_EX register and execute stage. Generates the stall and flush controls for the IF/ID and DE_EX pipeline registers, covering three cases: load-use hazards, redirects resolved in execute, and multi-cycle multiplies. Produces forwarding selects for the execute-stage operands. Holds the multiply-busy state machine and a stall-cycle performance counter.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_forward_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_forward_unit.sv
// Operand bypass select for one execute-stage source register.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  logic       wr_en_m_i,
  input  logic [4:0] wr_addr_m_i,
  input  logic       wr_en_w_i,
  input  logic [4:0] wr_addr_w_i,
  output logic [1:0] fwd_sel_o
);

  // The younger MEM result wins when both later stages target the same register.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (wr_en_m_i && (wr_addr_m_i != 5'd0) && (wr_addr_m_i == rs_addr_i)) begin
      fwd_sel_o = FWD_MEM;
    end else if (wr_en_w_i && (wr_addr_w_i != 5'd0) && (wr_addr_w_i == rs_addr_i)) begin
      fwd_sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencing for IF/ID and DE_EX, multiply-busy FSM,
// operand forwarding selects and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        reg_read_addr1_d,
  input  logic [4:0]        reg_read_addr2_d,
  input  logic [4:0]        reg_read_addr1_e,
  input  logic [4:0]        reg_read_addr2_e,
  input  logic              reg_write_en_e,
  input  logic [4:0]        reg_write_addr_e,
  input  logic              dmem_read_en_e,
  input  logic              mul_en_e,
  input  logic              pc_redirect_e,
  input  logic              reg_write_en_m,
  input  logic [4:0]        reg_write_addr_m,
  input  logic              reg_write_en_w,
  input  logic [4:0]        reg_write_addr_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              stall_e,
  output logic              flush_e,
  output logic              mul_done,
  output logic [1:0]        fwd_sel1_e,
  output logic [1:0]        fwd_sel2_e,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int CW = $clog2(MUL_LATENCY) + 1;
  localparam logic [CW-1:0] CNT_INIT = (MUL_LATENCY >= 2) ? CW'(MUL_LATENCY - 2) : '0;

  mul_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_cycles_q;
  logic              busy;
  logic              mul_done_raw;
  logic              loaduse;

  // Multiply occupancy: the first cycle is spent in IDLE, remaining ones in BUSY.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy         = 1'b0;
    mul_done_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (mul_en_e) begin
          if (MUL_LATENCY == 1) begin
            mul_done_raw = 1'b1;
          end else begin
            busy    = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          busy  = 1'b1;
          cnt_d = cnt_q - CW'(1);
        end else begin
          mul_done_raw = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign loaduse = dmem_read_en_e && reg_write_en_e && (reg_write_addr_e != 5'd0) &&
                   ((reg_write_addr_e == reg_read_addr1_d) ||
                    (reg_write_addr_e == reg_read_addr2_d));

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
    end else if (pc_redirect_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (loaduse) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign mul_done = reset && mul_done_raw;

  logic [4:0] rs_e [2];
  logic [1:0] fwd_raw [2];

  assign rs_e[0] = reg_read_addr1_e;
  assign rs_e[1] = reg_read_addr2_e;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      forward_unit u_fwd (
        .rs_addr_i   (rs_e[gi]),
        .wr_en_m_i   (reg_write_en_m),
        .wr_addr_m_i (reg_write_addr_m),
        .wr_en_w_i   (reg_write_en_w),
        .wr_addr_w_i (reg_write_addr_w),
        .fwd_sel_o   (fwd_raw[gi])
      );
    end
  endgenerate

  assign fwd_sel1_e = reset ? fwd_raw[0] : FWD_RF;
  assign fwd_sel2_e = reset ? fwd_raw[1] : FWD_RF;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_f && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + PERF_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: combinational vector table plus hand sequences for the
// multiply FSM, asynchronous reset and counter saturation.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       we_e, ld_e, mul_e, redir_e, we_m, we_w;

  // Main instance: MUL_LATENCY=3, PERF_W=32
  logic        m_sf, m_sd, m_fd, m_se, m_fe, m_done;
  logic [1:0]  m_f1, m_f2;
  logic [31:0] m_cnt;
  // Single-cycle multiply instance
  logic        s_sf, s_sd, s_fd, s_se, s_fe, s_done;
  logic [1:0]  s_f1, s_f2;
  logic [31:0] s_cnt;
  // Narrow counter instance
  logic        p_sf, p_sd, p_fd, p_se, p_fe, p_done;
  logic [1:0]  p_f1, p_f2;
  logic [3:0]  p_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_ctrl #(.MUL_LATENCY(3), .PERF_W(32)) dut (
    .clk(clk), .reset(reset),
    .reg_read_addr1_d(rs1_d), .reg_read_addr2_d(rs2_d),
    .reg_read_addr1_e(rs1_e), .reg_read_addr2_e(rs2_e),
    .reg_write_en_e(we_e), .reg_write_addr_e(rd_e),
    .dmem_read_en_e(ld_e), .mul_en_e(mul_e), .pc_redirect_e(redir_e),
    .reg_write_en_m(we_m), .reg_write_addr_m(rd_m),
    .reg_write_en_w(we_w), .reg_write_addr_w(rd_w),
    .stall_f(m_sf), .stall_d(m_sd), .flush_d(m_fd), .stall_e(m_se), .flush_e(m_fe),
    .mul_done(m_done), .fwd_sel1_e(m_f1), .fwd_sel2_e(m_f2), .stall_cycles(m_cnt)
  );

  hazard_ctrl #(.MUL_LATENCY(1), .PERF_W(32)) dut_lat1 (
    .clk(clk), .reset(reset),
    .reg_read_addr1_d(rs1_d), .reg_read_addr2_d(rs2_d),
    .reg_read_addr1_e(rs1_e), .reg_read_addr2_e(rs2_e),
    .reg_write_en_e(we_e), .reg_write_addr_e(rd_e),
    .dmem_read_en_e(ld_e), .mul_en_e(mul_e), .pc_redirect_e(redir_e),
    .reg_write_en_m(we_m), .reg_write_addr_m(rd_m),
    .reg_write_en_w(we_w), .reg_write_addr_w(rd_w),
    .stall_f(s_sf), .stall_d(s_sd), .flush_d(s_fd), .stall_e(s_se), .flush_e(s_fe),
    .mul_done(s_done), .fwd_sel1_e(s_f1), .fwd_sel2_e(s_f2), .stall_cycles(s_cnt)
  );

  hazard_ctrl #(.MUL_LATENCY(3), .PERF_W(4)) dut_perf4 (
    .clk(clk), .reset(reset),
    .reg_read_addr1_d(rs1_d), .reg_read_addr2_d(rs2_d),
    .reg_read_addr1_e(rs1_e), .reg_read_addr2_e(rs2_e),
    .reg_write_en_e(we_e), .reg_write_addr_e(rd_e),
    .dmem_read_en_e(ld_e), .mul_en_e(mul_e), .pc_redirect_e(redir_e),
    .reg_write_en_m(we_m), .reg_write_addr_m(rd_m),
    .reg_write_en_w(we_w), .reg_write_addr_w(rd_w),
    .stall_f(p_sf), .stall_d(p_sd), .flush_d(p_fd), .stall_e(p_se), .flush_e(p_fe),
    .mul_done(p_done), .fwd_sel1_e(p_f1), .fwd_sel2_e(p_f2), .stall_cycles(p_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e;
    logic       we_e;
    logic [4:0] rd_e;
    logic       ld_e, redir;
    logic       we_m;
    logic [4:0] rd_m;
    logic       we_w;
    logic [4:0] rd_w;
    logic [4:0] ctrl;   // {stall_f, stall_d, flush_d, stall_e, flush_e}
    logic [1:0] fwd1, fwd2;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    we_e = 0; ld_e = 0; mul_e = 0; redir_e = 0; we_m = 0; we_w = 0;
  endtask

  task automatic chk_ctrl(input string name, input logic [4:0] exp);
    chk(name, {27'd0, m_sf, m_sd, m_fd, m_se, m_fe}, {27'd0, exp});
  endtask

  // Drive at a negedge, evaluate 1 time unit later, then advance one full cycle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  initial begin
    clear_inputs();
    // Matching forwarding inputs during reset must still read back as regfile.
    we_m = 1; rd_m = 7; rs1_e = 7;
    reset = 1'b0;
    #3;
    chk_ctrl("reset_ctrl", 5'b00101);
    chk("reset_fwd1", {30'd0, m_f1}, 32'd0);
    chk("reset_mul_done", {31'd0, m_done}, 32'd0);
    chk("reset_cnt", m_cnt, 32'd0);
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    next_cycle();

    //           rs1d rs2d rs1e rs2e weE rdE ld  rd  weM rdM weW rdW  ctrl     f1     f2
    vecs[0]  = '{0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  0,  0,  5'b00000, 2'b00, 2'b00};
    vecs[1]  = '{1,   5,   0,   0,   1,  5,  1,  0,  0,  0,  0,  0,  5'b11001, 2'b00, 2'b00};
    vecs[2]  = '{5,   2,   0,   0,   1,  5,  1,  0,  0,  0,  0,  0,  5'b11001, 2'b00, 2'b00};
    vecs[3]  = '{0,   0,   0,   0,   1,  0,  1,  0,  0,  0,  0,  0,  5'b00000, 2'b00, 2'b00};
    vecs[4]  = '{1,   5,   0,   0,   0,  5,  1,  0,  0,  0,  0,  0,  5'b00000, 2'b00, 2'b00};
    vecs[5]  = '{5,   2,   0,   0,   1,  5,  0,  0,  0,  0,  0,  0,  5'b00000, 2'b00, 2'b00};
    vecs[6]  = '{1,   5,   0,   0,   1,  5,  1,  1,  0,  0,  0,  0,  5'b00101, 2'b00, 2'b00};
    vecs[7]  = '{0,   0,   0,   0,   0,  0,  0,  1,  0,  0,  0,  0,  5'b00101, 2'b00, 2'b00};
    vecs[8]  = '{0,   0,   7,   3,   0,  0,  0,  0,  1,  7,  1,  7,  5'b00000, 2'b01, 2'b00};
    vecs[9]  = '{0,   0,   7,   3,   0,  0,  0,  0,  0,  7,  1,  7,  5'b00000, 2'b10, 2'b00};
    vecs[10] = '{0,   0,   0,   0,   0,  0,  0,  0,  1,  0,  1,  0,  5'b00000, 2'b00, 2'b00};
    vecs[11] = '{0,   0,   4,   9,   0,  0,  0,  0,  1,  4,  1,  9,  5'b00000, 2'b01, 2'b10};
    vecs[12] = '{5,   0,   5,   0,   1,  5,  1,  0,  1,  5,  0,  0,  5'b11001, 2'b01, 2'b00};

    for (int i = 0; i < 13; i++) begin
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
      rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e;
      we_e = vecs[i].we_e; rd_e = vecs[i].rd_e; ld_e = vecs[i].ld_e;
      redir_e = vecs[i].redir; mul_e = 1'b0;
      we_m = vecs[i].we_m; rd_m = vecs[i].rd_m;
      we_w = vecs[i].we_w; rd_w = vecs[i].rd_w;
      #1;
      chk($sformatf("vec%0d_ctrl", i), {27'd0, m_sf, m_sd, m_fd, m_se, m_fe}, {27'd0, vecs[i].ctrl});
      chk($sformatf("vec%0d_fwd1", i), {30'd0, m_f1}, {30'd0, vecs[i].fwd1});
      chk($sformatf("vec%0d_fwd2", i), {30'd0, m_f2}, {30'd0, vecs[i].fwd2});
      $display("vector %0d ctrl=%b fwd1=%b fwd2=%b", i, {m_sf, m_sd, m_fd, m_se, m_fe}, m_f1, m_f2);
      next_cycle();
    end
    clear_inputs();

    // Load-use stall lasts one cycle and bumps the counter once.
    pulse_reset();
    we_e = 1; ld_e = 1; rd_e = 5; rs2_d = 5;
    #1;
    chk_ctrl("lu_stall", 5'b11001);
    chk("lu_cnt_before", m_cnt, 32'd0);
    next_cycle();
    clear_inputs();
    #1;
    chk_ctrl("lu_bubble", 5'b00000);
    chk("lu_cnt_after", m_cnt, 32'd1);
    $display("load-use sequence stall_cycles=%0d", m_cnt);
    next_cycle();

    // Multiply, latency 3, held mul_en gives back-to-back sequences.
    pulse_reset();
    mul_e = 1;
    #1;
    chk_ctrl("mul_t0_ctrl", 5'b11010);
    chk("mul_t0_done", {31'd0, m_done}, 32'd0);
    chk("lat1_done", {31'd0, s_done}, 32'd1);
    chk("lat1_stall_e", {31'd0, s_se}, 32'd0);
    next_cycle();
    redir_e = 1;
    #1;
    chk_ctrl("mul_t1_redir_ignored", 5'b11010);
    chk("mul_t1_done", {31'd0, m_done}, 32'd0);
    next_cycle();
    redir_e = 0;
    #1;
    chk_ctrl("mul_t2_ctrl", 5'b00000);
    chk("mul_t2_done", {31'd0, m_done}, 32'd1);
    next_cycle();
    #1;
    chk_ctrl("mul_t3_restart", 5'b11010);
    chk("mul_t3_done", {31'd0, m_done}, 32'd0);
    next_cycle();
    mul_e = 0;
    #1;
    chk("mul_t4_stall_e", {31'd0, m_se}, 32'd1);
    next_cycle();
    #1;
    chk("mul_t5_done", {31'd0, m_done}, 32'd1);
    next_cycle();
    #1;
    chk_ctrl("mul_t6_idle", 5'b00000);
    chk("mul_t6_done", {31'd0, m_done}, 32'd0);
    $display("multiply sequence stall_cycles=%0d", m_cnt);
    next_cycle();

    // Asynchronous reset while BUSY with cnt=1 abandons the multiply.
    mul_e = 1;
    next_cycle();
    mul_e = 0;
    #1;
    chk("busy_before_reset", {31'd0, m_se}, 32'd1);
    reset = 1'b0;
    #1;
    chk_ctrl("async_reset_ctrl", 5'b00101);
    chk("async_reset_cnt", m_cnt, 32'd0);
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("post_reset_c%0d_ctrl", c), {27'd0, m_sf, m_sd, m_fd, m_se, m_fe}, 32'd0);
      chk($sformatf("post_reset_c%0d_done", c), {31'd0, m_done}, 32'd0);
      next_cycle();
    end
    $display("reset-in-busy sequence stall_cycles=%0d", m_cnt);

    // Saturation: 19 consecutive stall cycles.
    pulse_reset();
    we_e = 1; ld_e = 1; rd_e = 3; rs1_d = 3;
    for (int c = 0; c < 14; c++) next_cycle();
    #1;
    chk("sat_p4_at14", {28'd0, p_cnt}, 32'd14);
    for (int c = 0; c < 5; c++) next_cycle();
    #1;
    chk("sat_p4_at19", {28'd0, p_cnt}, 32'd15);
    chk("sat_p32_at19", m_cnt, 32'd19);
    $display("saturation sequence p4=%0d p32=%0d", p_cnt, m_cnt);
    clear_inputs();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
